// File: rtl/ram_port_arbiter.sv
// Shares port A of a dual-port block RAM between two requesters, and zeroes the
// whole array after reset before any requester is served.
module ram_port_arbiter #(
    parameter int width          = 8,
    parameter int widthad        = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [widthad-1:0] m0_addr,
    input  logic [width-1:0]   m0_wdata,
    output logic               m0_ack,
    output logic               m0_rvalid,
    output logic [width-1:0]   m0_rdata,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [widthad-1:0] m1_addr,
    input  logic [width-1:0]   m1_wdata,
    output logic               m1_ack,
    output logic               m1_rvalid,
    output logic [width-1:0]   m1_rdata,
    output logic [widthad-1:0] ram_address,
    output logic               ram_wren,
    output logic [width-1:0]   ram_data,
    input  logic [width-1:0]   ram_q,
    output logic               busy
);

    localparam logic [widthad-1:0] LAST_ADDR = {widthad{1'b1}};
    localparam logic [widthad-1:0] CNT_ONE   = {{(widthad-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state_r;
    logic [widthad-1:0] clr_cnt_r;
    logic [widthad-1:0] last_addr_r;
    logic               last_grant_r;   // 1: requester 1 was granted most recently
    logic               m0_rvalid_r;
    logic               m1_rvalid_r;
    logic               grant0_s;
    logic               grant1_s;
    logic [widthad-1:0] ram_address_s;
    logic               ram_wren_s;
    logic [width-1:0]   ram_data_s;

    // Round-robin grant on the current requests; nothing is granted in reset or CLEAR
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst && (state_r == ST_RUN)) begin
            if (m0_req && m1_req) begin
                grant0_s = last_grant_r;
                grant1_s = ~last_grant_r;
            end else begin
                grant0_s = m0_req;
                grant1_s = m1_req;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Port A drive: clear sweep, granted requester, or idle holding the last address
    always_comb begin
        ram_address_s = last_addr_r;
        ram_wren_s    = 1'b0;
        ram_data_s    = '0;
        if (rst) begin
            ram_wren_s = 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    ram_address_s = clr_cnt_r;
                    ram_wren_s    = 1'b1;
                end
                ST_RUN: begin
                    if (grant0_s) begin
                        ram_address_s = m0_addr;
                        ram_wren_s    = m0_we;
                        ram_data_s    = m0_wdata;
                    end else if (grant1_s) begin
                        ram_address_s = m1_addr;
                        ram_wren_s    = m1_we;
                        ram_data_s    = m1_wdata;
                    end else begin
                        ram_wren_s = 1'b0;
                    end
                end
                default: begin
                    ram_wren_s = 1'b0;
                end
            endcase
        end
    end

    // Clear sequencing, grant pointer and read-return tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_r    <= '0;
            last_addr_r  <= '0;
            last_grant_r <= 1'b1;
            m0_rvalid_r  <= 1'b0;
            m1_rvalid_r  <= 1'b0;
        end else begin
            m0_rvalid_r <= grant0_s & ~m0_we;
            m1_rvalid_r <= grant1_s & ~m1_we;
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_r <= ST_RUN;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (grant0_s) begin
                        last_grant_r <= 1'b0;
                        last_addr_r  <= m0_addr;
                    end else if (grant1_s) begin
                        last_grant_r <= 1'b1;
                        last_addr_r  <= m1_addr;
                    end else begin
                        last_grant_r <= last_grant_r;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                end
            endcase
        end
    end

    assign m0_ack      = grant0_s;
    assign m1_ack      = grant1_s;
    assign m0_rvalid   = m0_rvalid_r;
    assign m1_rvalid   = m1_rvalid_r;
    assign m0_rdata    = ram_q;
    assign m1_rdata    = ram_q;
    assign ram_address = ram_address_s;
    assign ram_wren    = ram_wren_s;
    assign ram_data    = ram_data_s;
    assign busy        = rst | (state_r == ST_CLEAR);

endmodule
